// File: rtl/bcd_entry_pkg.sv
// Shared types and constants for the BCD setpoint entry block.
// Button indices match the PUSH_BUTTON_N_I bit order.
package bcd_entry_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EDIT = 2'd1,
        S_REQ  = 2'd2
    } entry_state_t;

    typedef enum logic {
        SEL_ONES = 1'b0,
        SEL_TENS = 1'b1
    } digit_sel_t;

    localparam int PB_EDIT = 0;
    localparam int PB_INC  = 1;
    localparam int PB_DEC  = 2;
    localparam int PB_SEL  = 3;
    localparam int NUM_PB  = 4;

    // Binary value of a two-digit BCD number, built from shifts (x8 + x2).
    function automatic logic [7:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] ones);
        logic [7:0] t;
        t = {4'd0, tens};
        return (t << 3) + (t << 1) + {4'd0, ones};
    endfunction

endpackage

// File: rtl/bcd_setpoint_entry_debounce.sv
// Push-button debouncer: internal 1 kHz tick, per-button shift registers,
// registered pressed status and one-cycle press pulses on status rising.
module pb_debounce
    import bcd_entry_pkg::*;
#(
    parameter int MAX_1kHz_div_count = 24999,
    parameter int DEBOUNCE_LEN       = 10
) (
    input  logic              CLOCK_50_I,
    input  logic              resetn,
    input  logic [NUM_PB-1:0] i_pb_n,
    output logic [NUM_PB-1:0] o_press,
    output logic              o_tick
);

    localparam int DW = (MAX_1kHz_div_count > 0) ? $clog2(MAX_1kHz_div_count + 1) : 1;

    logic [DW-1:0]                       r_div_cnt;
    logic                                r_tick_lvl;
    logic [NUM_PB-1:0][DEBOUNCE_LEN-1:0] r_shift;
    logic [NUM_PB-1:0]                   r_status;
    logic [NUM_PB-1:0]                   r_status_d;
    logic                                w_div_wrap;
    logic                                w_tick_rise;

    assign w_div_wrap  = (r_div_cnt == DW'(MAX_1kHz_div_count));
    // The tick level is about to go 0->1: sample the buttons on this edge.
    assign w_tick_rise = w_div_wrap && !r_tick_lvl;

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, exactly like the hardware.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_div_cnt  <= '0;
            r_tick_lvl <= 1'b1;
            r_shift    <= '0;
            r_status   <= '0;
            r_status_d <= '0;
        end else begin
            if (w_div_wrap) begin
                r_div_cnt  <= '0;
                r_tick_lvl <= ~r_tick_lvl;
            end else begin
                r_div_cnt  <= r_div_cnt + 1'b1;
            end
            if (w_tick_rise) begin
                for (int i = 0; i < NUM_PB; i++)
                    r_shift[i] <= {r_shift[i][DEBOUNCE_LEN-2:0], ~i_pb_n[i]};
            end
            for (int i = 0; i < NUM_PB; i++)
                r_status[i] <= |r_shift[i];
            r_status_d <= r_status;
        end
    end

    assign o_press = r_status & ~r_status_d;
    assign o_tick  = w_tick_rise;

endmodule

// File: rtl/bcd_setpoint_entry.sv
// Two-digit BCD setpoint entry: edit FSM, digit arithmetic with wrap/clamp,
// blink mask for the selected digit and valid/ready load handshake.
module bcd_setpoint_entry
    import bcd_entry_pkg::*;
#(
    parameter int MAX_1kHz_div_count = 24999,
    parameter int DEBOUNCE_LEN       = 10,
    parameter int BLINK_DIV          = 249,
    parameter int MAX_VALUE          = 59
) (
    input  logic              CLOCK_50_I,
    input  logic              resetn,
    input  logic [NUM_PB-1:0] PUSH_BUTTON_N_I,
    input  logic              load_ready,
    output logic              load_valid,
    output logic [7:0]        load_value,
    output logic [3:0]        digit_ones,
    output logic [3:0]        digit_tens,
    output logic [1:0]        blank_mask,
    output logic              editing
);

    localparam logic [3:0] TENS_MAX  = 4'(MAX_VALUE / 10);
    localparam logic [3:0] ONES_CLMP = 4'(MAX_VALUE % 10);
    localparam int         BW        = (BLINK_DIV > 0) ? $clog2(BLINK_DIV + 1) : 1;

    entry_state_t r_state, w_state_nxt;
    digit_sel_t   r_sel, w_sel_nxt;
    logic [3:0]   r_ones, r_tens, w_ones_nxt, w_tens_nxt;
    logic         r_load_valid, w_valid_nxt;
    logic [7:0]   r_load_value, w_value_nxt;
    logic [BW-1:0] r_blink_cnt;
    logic         r_phase;
    logic         w_restart;

    logic [NUM_PB-1:0] w_press;
    logic              w_tick;
    logic              w_do_edit, w_do_sel, w_do_inc, w_do_dec;
    logic [3:0]        w_ones_step, w_tens_step, w_ones_cand, w_tens_cand;

    pb_debounce #(
        .MAX_1kHz_div_count (MAX_1kHz_div_count),
        .DEBOUNCE_LEN       (DEBOUNCE_LEN)
    ) u_debounce (
        .CLOCK_50_I (CLOCK_50_I),
        .resetn     (resetn),
        .i_pb_n     (PUSH_BUTTON_N_I),
        .o_press    (w_press),
        .o_tick     (w_tick)
    );

    // Only the highest-priority press acts: EDIT > SEL > INC > DEC.
    assign w_do_edit = w_press[PB_EDIT];
    assign w_do_sel  = w_press[PB_SEL] && !w_do_edit;
    assign w_do_inc  = w_press[PB_INC] && !w_do_edit && !w_do_sel;
    assign w_do_dec  = w_press[PB_DEC] && !w_do_edit && !w_do_sel && !w_do_inc;

    assign w_ones_step = w_do_inc ? ((r_ones == 4'd9) ? 4'd0 : r_ones + 4'd1)
                                  : ((r_ones == 4'd0) ? 4'd9 : r_ones - 4'd1);
    assign w_tens_step = w_do_inc ? ((r_tens == TENS_MAX) ? 4'd0 : r_tens + 4'd1)
                                  : ((r_tens == 4'd0) ? TENS_MAX : r_tens - 4'd1);
    assign w_tens_cand = (r_sel == SEL_TENS) ? w_tens_step : r_tens;
    assign w_ones_cand = (r_sel == SEL_ONES) ? w_ones_step : r_ones;

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_ones_nxt  = r_ones;
        w_tens_nxt  = r_tens;
        w_valid_nxt = r_load_valid;
        w_value_nxt = r_load_value;
        w_restart   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_do_edit) begin
                    w_state_nxt = S_EDIT;
                    w_sel_nxt   = SEL_ONES;
                    w_restart   = 1'b1;
                end
            end
            S_EDIT: begin
                if (w_do_edit) begin
                    w_state_nxt = S_REQ;
                    w_valid_nxt = 1'b1;
                    w_value_nxt = bcd_to_bin(r_tens, r_ones);
                end else if (w_do_sel) begin
                    w_sel_nxt = (r_sel == SEL_ONES) ? SEL_TENS : SEL_ONES;
                    w_restart = 1'b1;
                end else if (w_do_inc || w_do_dec) begin
                    w_tens_nxt = w_tens_cand;
                    w_ones_nxt = (bcd_to_bin(w_tens_cand, w_ones_cand) > 8'(MAX_VALUE))
                                 ? ONES_CLMP : w_ones_cand;
                    w_restart  = 1'b1;
                end
            end
            S_REQ: begin
                if (load_ready) begin
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_sel        <= SEL_ONES;
            r_ones       <= 4'd0;
            r_tens       <= 4'd0;
            r_load_valid <= 1'b0;
            r_load_value <= 8'd0;
            r_blink_cnt  <= '0;
            r_phase      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sel        <= w_sel_nxt;
            r_ones       <= w_ones_nxt;
            r_tens       <= w_tens_nxt;
            r_load_valid <= w_valid_nxt;
            r_load_value <= w_value_nxt;
            if (w_restart) begin
                r_blink_cnt <= '0;
                r_phase     <= 1'b0;
            end else if (r_state == S_EDIT && w_tick) begin
                if (r_blink_cnt == BW'(BLINK_DIV)) begin
                    r_blink_cnt <= '0;
                    r_phase     <= ~r_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        blank_mask = 2'b00;
        if (r_state == S_EDIT)
            blank_mask = (r_sel == SEL_TENS) ? {r_phase, 1'b0} : {1'b0, r_phase};
    end

    assign load_valid = r_load_valid;
    assign load_value = r_load_value;
    assign digit_ones = r_ones;
    assign digit_tens = r_tens;
    assign editing    = (r_state == S_EDIT);

endmodule

// File: tb/tb_bcd_setpoint_entry.sv
// Self-checking bench: two DUTs (MAX_VALUE 59 and 45) share buttons and handshake;
// a press-level reference model predicts digits, state and load value.
module tb_bcd_setpoint_entry;

    localparam int DIV  = 4;
    localparam int DLEN = 3;
    localparam int BDIV = 3;
    localparam int MAXV [2] = '{59, 45};

    logic       CLOCK_50_I = 1'b0;
    logic       resetn;
    logic [3:0] pb_n;
    logic       load_ready;

    logic       load_valid [2];
    logic [7:0] load_value [2];
    logic [3:0] digit_ones [2];
    logic [3:0] digit_tens [2];
    logic [1:0] blank_mask [2];
    logic       editing    [2];

    always #10 CLOCK_50_I = ~CLOCK_50_I;

    bcd_setpoint_entry #(
        .MAX_1kHz_div_count(DIV), .DEBOUNCE_LEN(DLEN), .BLINK_DIV(BDIV), .MAX_VALUE(59)
    ) u_dut59 (
        .CLOCK_50_I(CLOCK_50_I), .resetn(resetn), .PUSH_BUTTON_N_I(pb_n),
        .load_ready(load_ready), .load_valid(load_valid[0]), .load_value(load_value[0]),
        .digit_ones(digit_ones[0]), .digit_tens(digit_tens[0]),
        .blank_mask(blank_mask[0]), .editing(editing[0])
    );

    bcd_setpoint_entry #(
        .MAX_1kHz_div_count(DIV), .DEBOUNCE_LEN(DLEN), .BLINK_DIV(BDIV), .MAX_VALUE(45)
    ) u_dut45 (
        .CLOCK_50_I(CLOCK_50_I), .resetn(resetn), .PUSH_BUTTON_N_I(pb_n),
        .load_ready(load_ready), .load_valid(load_valid[1]), .load_value(load_value[1]),
        .digit_ones(digit_ones[1]), .digit_tens(digit_tens[1]),
        .blank_mask(blank_mask[1]), .editing(editing[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: 0 idle, 1 edit, 2 request; sel 0 ones, 1 tens.
    int m_state;
    int m_sel;
    int m_ones [2];
    int m_tens [2];
    int m_val  [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_sel   = 0;
        for (int k = 0; k < 2; k++) begin
            m_ones[k] = 0;
            m_tens[k] = 0;
            m_val[k]  = 0;
        end
    endtask

    task automatic model_press(input int b);
        int tmax;
        case (m_state)
            0: if (b == 0) begin m_state = 1; m_sel = 0; end
            1: begin
                if (b == 0) begin
                    m_state = 2;
                    for (int k = 0; k < 2; k++) m_val[k] = m_tens[k] * 10 + m_ones[k];
                end else if (b == 3) begin
                    m_sel = 1 - m_sel;
                end else begin
                    for (int k = 0; k < 2; k++) begin
                        tmax = MAXV[k] / 10;
                        if (m_sel == 0)
                            m_ones[k] = (b == 1) ? (m_ones[k] + 1) % 10 : (m_ones[k] + 9) % 10;
                        else if (b == 1)
                            m_tens[k] = (m_tens[k] == tmax) ? 0 : m_tens[k] + 1;
                        else
                            m_tens[k] = (m_tens[k] == 0) ? tmax : m_tens[k] - 1;
                        if (m_tens[k] * 10 + m_ones[k] > MAXV[k]) m_ones[k] = MAXV[k] % 10;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_ones%0d", tag, k), digit_ones[k], m_ones[k]);
            check($sformatf("%s_tens%0d", tag, k), digit_tens[k], m_tens[k]);
            check($sformatf("%s_valid%0d", tag, k), load_valid[k], m_state == 2);
            check($sformatf("%s_value%0d", tag, k), load_value[k], m_val[k]);
            check($sformatf("%s_editing%0d", tag, k), editing[k], m_state == 1);
            if (m_state == 1)
                check($sformatf("%s_blank_other%0d", tag, k), blank_mask[k][1 - m_sel], 0);
            else
                check($sformatf("%s_blank%0d", tag, k), blank_mask[k], 0);
        end
    endtask

    // Hold the masked buttons low long enough to debounce, then release and settle.
    // Optional bounce phase toggles the buttons at random for 15 cycles first.
    task automatic press_btn(input logic [3:0] mask, input bit bouncy,
                             output int vcyc, output int vval);
        vcyc = 0;
        vval = -1;
        if (bouncy) begin
            for (int i = 0; i < 15; i++) begin
                @(negedge CLOCK_50_I);
                pb_n = $urandom_range(0, 1) ? ~mask : 4'hF;
            end
        end
        @(negedge CLOCK_50_I);
        pb_n = ~mask;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLOCK_50_I);
            if (i == 40) pb_n = 4'hF;
            if (load_valid[0]) begin vcyc++; vval = load_value[0]; end
        end
    endtask

    task automatic do_press(input int b);
        int vc, vv;
        press_btn(4'(1 << b), 1'b0, vc, vv);
        model_press(b);
        check_all($sformatf("pb%0d", b));
    endtask

    // Hold load_ready low for a while checking the offer stays put, then pulse it.
    task automatic handshake(input int wait_cycles);
        int moved;
        moved = 0;
        load_ready = 1'b0;
        for (int i = 0; i < wait_cycles; i++) begin
            @(negedge CLOCK_50_I);
            for (int k = 0; k < 2; k++)
                if (load_valid[k] !== 1'b1 || load_value[k] !== 8'(m_val[k])) moved++;
        end
        check("req_stable", moved, 0);
        load_ready = 1'b1;
        @(negedge CLOCK_50_I);
        load_ready = 1'b0;
        m_state = 0;
        check_all("handshake");
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        repeat (5) @(negedge CLOCK_50_I);
        resetn = 1'b1;
        model_reset();
        repeat (5) @(negedge CLOCK_50_I);
    endtask

    initial begin
        int vc, vv, seen0, seen1, other, r, b;
        logic [3:0] o_save, t_save;
        pb_n       = 4'hF;
        load_ready = 1'b0;
        resetn     = 1'b0;
        model_reset();
        #35;
        resetn = 1'b1;

        // Idle after reset: nothing offered, digits 00, no blink.
        repeat (1000) @(negedge CLOCK_50_I);
        check_all("reset_idle");

        // Enter 23 and commit.
        do_press(0);
        repeat (3) do_press(1);
        do_press(3);
        repeat (2) do_press(1);
        do_press(0);
        check("seq23_tens", digit_tens[0], 2);
        check("seq23_ones", digit_ones[0], 3);
        check("seq23_valid", load_valid[0], 1);
        check("seq23_value", load_value[0], 23);
        do_press(1);                       // ignored while requesting
        handshake(50);

        // Wrap behaviour on the 59 instance.
        do_press(0);
        repeat (6) do_press(1);
        do_press(3);
        repeat (3) do_press(1);
        check("at59_value", {digit_tens[0], digit_ones[0]}, 8'h59);
        do_press(3);
        do_press(1);
        check("ones_wrap_up", digit_ones[0], 0);
        do_press(3);
        do_press(1);
        check("tens_wrap_up", digit_tens[0], 0);
        do_press(2);
        check("tens_wrap_down", digit_tens[0], 5);

        // Blink: selected digit toggles, other digit never blanked.
        seen0 = 0; seen1 = 0; other = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge CLOCK_50_I);
            if (blank_mask[0][1]) seen1++; else seen0++;
            if (blank_mask[0][0]) other++;
        end
        check("blink_on_seen", seen1 > 0, 1);
        check("blink_off_seen", seen0 > 0, 1);
        check("blink_other", other, 0);

        // Commit and edit press in the same cycle: commit only.
        o_save = digit_ones[0];
        t_save = digit_tens[0];
        press_btn(4'b0011, 1'b0, vc, vv);
        model_press(0);
        check("dual_ones", digit_ones[0], o_save);
        check("dual_tens", digit_tens[0], t_save);
        check_all("dual");
        handshake($urandom_range(2, 20));

        // Bouncy presses count once.
        press_btn(4'b0001, 1'b1, vc, vv);
        model_press(0);
        check_all("bounce_edit");
        press_btn(4'b0010, 1'b1, vc, vv);
        model_press(1);
        check_all("bounce_inc");

        // load_ready held high: one-cycle offer.
        load_ready = 1'b1;
        press_btn(4'b0001, 1'b0, vc, vv);
        model_press(0);
        check("oneshot_cycles", vc, 1);
        check("oneshot_value", vv, m_val[0]);
        m_state = 0;
        check_all("oneshot");
        load_ready = 1'b0;

        // Asynchronous reset while offering.
        do_press(0);
        do_press(1);
        do_press(0);
        check("prereset_valid", load_valid[0], 1);
        @(posedge CLOCK_50_I);
        #3 resetn = 1'b0;
        #1;
        check("async_valid0", load_valid[0], 0);
        check("async_valid1", load_valid[1], 0);
        repeat (3) @(negedge CLOCK_50_I);
        resetn = 1'b1;
        model_reset();
        repeat (20) @(negedge CLOCK_50_I);
        check_all("after_reset");

        // Clamp: 39 -> tens up -> 49 on MAX 59, 45 on MAX 45.
        do_press(0);
        do_press(2);
        do_press(3);
        repeat (3) do_press(1);
        do_press(1);
        check("clamp59", {digit_tens[0], digit_ones[0]}, 8'h49);
        check("clamp45", {digit_tens[1], digit_ones[1]}, 8'h45);
        do_press(0);
        check("clamp45_value", load_value[1], 45);
        handshake(5);

        // Randomized press sequence against the model.
        apply_reset();
        for (int it = 0; it < 70; it++) begin
            if (m_state == 2) begin
                if ($urandom_range(0, 2) == 0) do_press($urandom_range(1, 3));
                handshake($urandom_range(1, 20));
            end else begin
                r = $urandom_range(0, 9);
                b = (r == 0) ? 0 : (r <= 4) ? 1 : (r <= 7) ? 2 : 3;
                do_press(b);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
